// File: rtl/sreg_seq_pkg.sv
// ---------------------------------------------------------------------------
// sreg_seq_pkg
// Shared definitions for the shift-register sequencer family:
//   - default widths for the register datapath and the step counter
//   - 3-bit register mode encodings {s3,s2,s1}
//   - sequencer FSM state enum
//   - small helper to classify a mode as a shifting mode
// ---------------------------------------------------------------------------
package sreg_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  // Register mode encodings as seen on the {s3,s2,s1} select lines.
  localparam logic [2:0] OP_HOLD     = 3'b000;
  localparam logic [2:0] OP_SHR_FILL = 3'b001;
  localparam logic [2:0] OP_ROR      = 3'b010;
  localparam logic [2:0] OP_ASR      = 3'b011;
  localparam logic [2:0] OP_SHL_FILL = 3'b100;
  localparam logic [2:0] OP_SHL_REP  = 3'b101;
  localparam logic [2:0] OP_ROL      = 3'b110;
  localparam logic [2:0] OP_LOAD     = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // True for every mode that moves bits (everything except hold and load).
  function automatic logic op_is_shift(input logic [2:0] op);
    return (op != OP_HOLD) && (op != OP_LOAD);
  endfunction

endpackage

// File: rtl/sreg_step_counter.sv
// ---------------------------------------------------------------------------
// sreg_step_counter
// Loadable down-counter that tracks the remaining steps of a multi-cycle
// register operation. last_o flags the final step (remaining == 1) so the
// owning FSM can leave its stepping state on that same cycle.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (count returns to 0)
//   load_i     load load_val_i into the counter (wins over dec_i)
//   load_val_i initial number of steps
//   dec_i      consume one step; saturates at 0
//   last_o     remaining step count equals 1
// ---------------------------------------------------------------------------
module sreg_step_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_register_sequencer.sv
// ---------------------------------------------------------------------------
// shift_register_sequencer
// Command-driven controller for an 8-bit universal shift register. One
// command is accepted at a time (valid/ready); it becomes a single parallel
// load or N consecutive cycles of one shift/rotate mode. After the register
// has settled its parallel output is captured and returned with a separate
// valid/ready handshake. The register itself lives outside this block.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   cmd_valid      command present
//   cmd_ready      controller idle and able to accept
//   cmd_op         register mode {s3,s2,s1} (111 = load)
//   cmd_cnt        number of shift cycles (ignored for load)
//   cmd_data       load value
//   cmd_fill       serial fill bit for fill-shift modes
//   abort          cancel the command in progress
//   sr_sel         register mode select
//   sr_data        register parallel load data
//   sr_msb_in      register serial MSB input
//   sr_lsb_in      register serial LSB input
//   sr_q           register parallel output
//   result_valid   captured result available
//   result_ready   result consumed
//   result         captured register value
//   busy           controller not idle
// ---------------------------------------------------------------------------
module shift_register_sequencer
  import sreg_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_fill,
  input  logic              abort,
  output logic [2:0]        sr_sel,
  output logic [DATA_W-1:0] sr_data,
  output logic              sr_msb_in,
  output logic              sr_lsb_in,
  input  logic [DATA_W-1:0] sr_q,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  state_e            state_q;
  state_e            state_d;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic              fill_q;
  logic [DATA_W-1:0] result_q;

  logic accept;
  logic capture;
  logic step_last;
  logic abortable;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign abortable = (state_q == ST_LOAD) || (state_q == ST_SHIFT) ||
                     (state_q == ST_SETTLE);
  // SETTLE is the cycle where sr_q already holds the final value; an abort
  // arriving in that same cycle must still suppress the result.
  assign capture   = (state_q == ST_SETTLE) && !abort;

  sreg_step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (cmd_cnt),
    .dec_i      (state_q == ST_SHIFT),
    .last_o     (step_last)
  );

  // Next-state logic; abort overrides any transition out of the active states.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (!op_is_shift(cmd_op) || (cmd_cnt == '0)) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SHIFT:  if (step_last) state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_RESP;
      ST_RESP:   if (result_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort && abortable) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_HOLD;
      data_q   <= '0;
      fill_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        fill_q <= cmd_fill;
      end
      if (capture) begin
        result_q <= sr_q;
      end
    end
  end

  // Outputs are decoded from registered state only, so nothing on cmd_*
  // reaches the register select lines combinationally.
  always_comb begin
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    sr_sel       = OP_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LOAD:  sr_sel = OP_LOAD;
      ST_SHIFT: sr_sel = op_q;
      ST_RESP:  result_valid = 1'b1;
      default: begin
        sr_sel = OP_HOLD;
      end
    endcase
  end

  assign sr_data   = data_q;
  assign sr_msb_in = fill_q;
  assign sr_lsb_in = fill_q;
  assign result    = result_q;

endmodule
